hs_cdc_src: RTL

Source-domain half of the toggle-handshake CDC link: accepts words on a valid/ready interface in the `clk` domain and holds each word stable on `xfer_data`. It signals each new word by flipping `req_tgl`, which the destination-domain toggle synchronizer/pulse generator turns into a one-cycle strobe. It synchronizes the returning `ack_tgl` and edge-detects it to retire the transfer. A one-entry pending buffer lets the producer hand over the next word while the current one is in flight.

---
 rtl/hs_cdc_src_if.sv | 60 ++++++
 rtl/hs_cdc_src.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hs_cdc_src_if.sv
// ---------------------------------------------------------------------------
// hs_cdc_src_if
//   Signal bundle for the source half of the toggle-handshake CDC link.
//   Groups the producer valid/ready channel, the outgoing request toggle and
//   data word, the returning acknowledge toggle and the status outputs.
//
//   Ports (as interface signals):
//     src_valid    producer -> block   producer has a word
//     src_data     producer -> block   producer word (DW bits)
//     src_ready    block -> producer   block can accept a word
//     req_tgl      block -> dest       request toggle, flips per launched word
//     xfer_data    block -> dest       word in flight (DW bits)
//     ack_tgl      dest -> block       acknowledge toggle (async to clk)
//     busy         block -> observer   a transfer is awaiting acknowledge
//     done_pulse   block -> observer   one cycle per retired word
//     err_spurious block -> observer   sticky, ack edge seen while idle
//
//   Modports:
//     slave   the hs_cdc_src block itself
//     master  the environment (producer + destination side)
// ---------------------------------------------------------------------------
interface hs_cdc_src_if #(
  parameter int DW = 8
);

  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          req_tgl;
  logic [DW-1:0] xfer_data;
  logic          ack_tgl;
  logic          busy;
  logic          done_pulse;
  logic          err_spurious;

  modport slave (
    input  src_valid,
    input  src_data,
    input  ack_tgl,
    output src_ready,
    output req_tgl,
    output xfer_data,
    output busy,
    output done_pulse,
    output err_spurious
  );

  modport master (
    output src_valid,
    output src_data,
    output ack_tgl,
    input  src_ready,
    input  req_tgl,
    input  xfer_data,
    input  busy,
    input  done_pulse,
    input  err_spurious
  );

endinterface : hs_cdc_src_if

// File: rtl/hs_cdc_src.sv
// ---------------------------------------------------------------------------
// hs_cdc_src
//   Source-domain half of a toggle-handshake clock-domain-crossing link.
//   Words are accepted on a valid/ready channel and held stable on xfer_data
//   while in flight. Each launch flips req_tgl; the destination turns that
//   flip into a strobe, samples xfer_data and flips ack_tgl back. The
//   returning ack_tgl is synchronized here and edge-detected to retire the
//   word. A one-entry pending buffer lets the producer hand over the next
//   word while the current one is still in flight.
//
//   Parameters:
//     DW           data word width
//     SYNC_STAGES  flops in the ack_tgl synchronizer chain (2..4)
//
//   Ports:
//     clk    source-domain clock
//     rst_n  asynchronous, active-low reset
//     cdc    hs_cdc_src_if.slave bundle (see interface header)
// ---------------------------------------------------------------------------
module hs_cdc_src #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hs_cdc_src_if.slave  cdc
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_e                 state_q,       state_d;
  logic                   req_tgl_q,     req_tgl_d;
  logic [DW-1:0]          xfer_data_q,   xfer_data_d;
  logic [DW-1:0]          pend_data_q,   pend_data_d;
  logic                   pend_valid_q,  pend_valid_d;
  logic                   done_pulse_q,  done_pulse_d;
  logic                   err_spur_q,    err_spur_d;
  logic                   busy_q;
  logic                   src_ready_q;

  // Acknowledge synchronizer chain; bit 0 is the metastability-exposed flop.
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_prev_q;
  logic                   ack_s;
  logic                   ack_edge;
  logic                   accept;

  // -------------------------------------------------------------------------
  // Acknowledge path
  // -------------------------------------------------------------------------

  // Shift the raw ack toggle through the synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= {SYNC_STAGES{1'b0}};
      ack_prev_q <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], cdc.ack_tgl};
      ack_prev_q <= ack_s;
    end
  end

  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  // Any change of the synchronized toggle marks one acknowledged word.
  assign ack_edge = ack_s ^ ack_prev_q;

  // src_ready is a pure register, so accept never depends on ack_tgl.
  assign accept   = cdc.src_valid & src_ready_q;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------

  // Next-state and datapath update for the launch/retire handshake.
  always_comb begin
    state_d      = state_q;
    req_tgl_d    = req_tgl_q;
    xfer_data_d  = xfer_data_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    done_pulse_d = 1'b0;
    err_spur_d   = err_spur_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          xfer_data_d = cdc.src_data;
          req_tgl_d   = ~req_tgl_q;
          state_d     = ST_WAIT_ACK;
        end else begin
          state_d     = ST_IDLE;
        end
        // Nothing is in flight, so an acknowledge here is unexplained.
        if (ack_edge) begin
          err_spur_d = 1'b1;
        end else begin
          err_spur_d = err_spur_q;
        end
      end

      ST_WAIT_ACK: begin
        if (ack_edge) begin
          done_pulse_d = 1'b1;
          if (pend_valid_q) begin
            // Buffered word goes out on the same edge that retires the last.
            xfer_data_d  = pend_data_q;
            req_tgl_d    = ~req_tgl_q;
            pend_valid_d = 1'b0;
            state_d      = ST_WAIT_ACK;
          end else if (accept) begin
            // Empty buffer: the offered word bypasses straight to launch.
            xfer_data_d  = cdc.src_data;
            req_tgl_d    = ~req_tgl_q;
            state_d      = ST_WAIT_ACK;
          end else begin
            state_d      = ST_IDLE;
          end
        end else begin
          if (accept) begin
            pend_data_d  = cdc.src_data;
            pend_valid_d = 1'b1;
          end else begin
            pend_valid_d = pend_valid_q;
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_tgl_q    <= 1'b0;
      xfer_data_q  <= {DW{1'b0}};
      pend_data_q  <= {DW{1'b0}};
      pend_valid_q <= 1'b0;
      done_pulse_q <= 1'b0;
      err_spur_q   <= 1'b0;
      busy_q       <= 1'b0;
      src_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_tgl_q    <= req_tgl_d;
      xfer_data_q  <= xfer_data_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      done_pulse_q <= done_pulse_d;
      err_spur_q   <= err_spur_d;
      // Mirrors of state/pending kept as their own flops so the outputs
      // come straight off registers.
      busy_q       <= (state_d == ST_WAIT_ACK);
      src_ready_q  <= ~pend_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cdc.src_ready    = src_ready_q;
  assign cdc.req_tgl      = req_tgl_q;
  assign cdc.xfer_data    = xfer_data_q;
  assign cdc.busy         = busy_q;
  assign cdc.done_pulse   = done_pulse_q;
  assign cdc.err_spurious = err_spur_q;

endmodule : hs_cdc_src
